// File: rtl/instr_fetch_unit.sv
// PC / IR / MDR stage feeding ControlUnit in the multicycle RISCBlade core.
// Owns the instruction/data address mux and the combinational decode slices of IR.
module instr_fetch_unit #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             PCReset,
  input  logic             IR_EN,
  input  logic             IorD,
  input  logic             MemWrite,
  input  logic             BranchOut,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       op,
  output logic [3:0]       rd,
  output logic [3:0]       rs,
  output logic [WIDTH-1:0] imm8,
  output logic [WIDTH-1:0] imm12,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] inst_pc,
  output logic [WIDTH-1:0] mdr
);

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ir_reg;
  logic [WIDTH-1:0] inst_pc_reg;
  logic [WIDTH-1:0] mdr_reg;

  // Branch redirect outranks the fetch increment when both strobes coincide.
  always_comb begin
    pc_next = pc_reg;
    if (PCReset)
      pc_next = RESET_VEC;
    else if (BranchOut)
      pc_next = alu_result;
    else if (IR_EN)
      pc_next = pc_reg + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      pc_reg      <= RESET_VEC;
      ir_reg      <= '0;
      inst_pc_reg <= '0;
      mdr_reg     <= '0;
    end else begin
      pc_reg <= pc_next;
      if (IR_EN) begin
        ir_reg      <= mem_rdata;
        inst_pc_reg <= pc_reg;
      end
      if (IorD && !MemWrite)
        mdr_reg <= mem_rdata;
    end
  end

  assign mem_addr = IorD ? alu_result : pc_reg;
  assign op       = ir_reg[15:12];
  assign rd       = ir_reg[11:8];
  assign rs       = ir_reg[7:4];
  assign pc       = pc_reg;
  assign inst_pc  = inst_pc_reg;
  assign mdr      = mdr_reg;

  assign imm8[7:0]   = ir_reg[7:0];
  assign imm12[11:0] = ir_reg[11:0];

  genvar gi;
  generate
    for (gi = 8; gi < WIDTH; gi++) begin : g_imm8_sext
      assign imm8[gi] = ir_reg[7];
    end
    for (gi = 12; gi < WIDTH; gi++) begin : g_imm12_sext
      assign imm12[gi] = ir_reg[11];
    end
  endgenerate

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle compare against a behavioural
// model plus hand-computed literal checks for each scenario.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        PCReset = 1'b0;
  logic        IR_EN = 1'b0;
  logic        IorD = 1'b0;
  logic        MemWrite = 1'b0;
  logic        BranchOut = 1'b0;
  logic [15:0] alu_result = '0;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr;
  logic [3:0]  op, rd, rs;
  logic [15:0] imm8, imm12, pc, inst_pc, mdr;

  logic [15:0] mem [256];
  logic        use_mem = 1'b1;
  logic [15:0] forced_rdata = '0;
  logic        chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(.WIDTH(16), .RESET_VEC(16'h0000)) dut (
    .CLK(CLK), .reset(reset), .PCReset(PCReset), .IR_EN(IR_EN), .IorD(IorD),
    .MemWrite(MemWrite), .BranchOut(BranchOut), .alu_result(alu_result),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .op(op), .rd(rd), .rs(rs),
    .imm8(imm8), .imm12(imm12), .pc(pc), .inst_pc(inst_pc), .mdr(mdr)
  );

  always #5 CLK = ~CLK;

  // Memory answers whatever address the DUT presents.
  assign mem_rdata = use_mem ? mem[mem_addr[7:0]] : forced_rdata;

  // Behavioural model: architectural registers only.
  logic [15:0] m_pc, m_ir, m_ipc, m_mdr;
  logic [15:0] m_addr, m_rdata;
  assign m_addr  = IorD ? alu_result : m_pc;
  assign m_rdata = use_mem ? mem[m_addr[7:0]] : forced_rdata;

  always @(posedge CLK) begin
    if (reset) begin
      m_pc  <= 16'h0000;
      m_ir  <= 16'h0000;
      m_ipc <= 16'h0000;
      m_mdr <= 16'h0000;
    end else begin
      if (PCReset)        m_pc <= 16'h0000;
      else if (BranchOut) m_pc <= alu_result;
      else if (IR_EN)     m_pc <= 16'((32'(m_pc) + 1) % 65536);
      if (IR_EN) begin
        m_ir  <= m_rdata;
        m_ipc <= m_pc;
      end
      if (IorD && !MemWrite) m_mdr <= m_rdata;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_mem_addr", mem_addr, m_addr);
      check("model_pc", pc, m_pc);
      check("model_inst_pc", inst_pc, m_ipc);
      check("model_mdr", mdr, m_mdr);
      check("model_op", {12'h0, op}, {12'h0, m_ir[15:12]});
      check("model_rd", {12'h0, rd}, {12'h0, m_ir[11:8]});
      check("model_rs", {12'h0, rs}, {12'h0, m_ir[7:4]});
      check("model_imm8", imm8, 16'($signed(m_ir[7:0])));
      check("model_imm12", imm12, 16'($signed(m_ir[11:0])));
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input int n);
    IR_EN = 0; BranchOut = 0; PCReset = 0; IorD = 0; MemWrite = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  logic [3:0]  exp_op  [3] = '{4'h0, 4'h8, 4'h1};
  logic [15:0] exp_pc  [3] = '{16'h1, 16'h2, 16'h3};
  logic [15:0] exp_ipc [3] = '{16'h0, 16'h1, 16'h2};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101 + 16'h0F0F);
    mem[0] = 16'h0123; mem[1] = 16'h8456; mem[2] = 16'h1A7F;
    mem[5] = 16'h2345; mem[8'h40] = 16'h4F80; mem[8'hFF] = 16'h3000;

    // Initial reset, then scramble state before a mid-instruction reset.
    reset = 1; step(); step();
    chk_en = 1;
    reset = 0;
    IR_EN = 1; step(); step(); step();
    IR_EN = 0; BranchOut = 1; alu_result = 16'h0033; step();
    BranchOut = 0; IorD = 1; alu_result = 16'h0007; step();
    IorD = 0; reset = 1; IR_EN = 1; step();
    reset = 0; IR_EN = 0;
    check("rst_pc", pc, 16'h0000);
    check("rst_op", {12'h0, op}, 16'h0000);
    check("rst_imm12", imm12, 16'h0000);
    check("rst_inst_pc", inst_pc, 16'h0000);
    check("rst_mdr", mdr, 16'h0000);
    check("rst_mem_addr", mem_addr, 16'h0000);

    // Sequential fetch, one fetch every 4 cycles.
    for (int k = 0; k < 3; k++) begin
      IR_EN = 1; step(); IR_EN = 0;
      check($sformatf("fetch%0d_op", k), {12'h0, op}, {12'h0, exp_op[k]});
      check($sformatf("fetch%0d_pc", k), pc, exp_pc[k]);
      check($sformatf("fetch%0d_inst_pc", k), inst_pc, exp_ipc[k]);
      idle(3);
    end
    check("fetch_imm8", imm8, 16'h007F);

    // Branch alone, then branch coinciding with fetch.
    BranchOut = 1; alu_result = 16'h0005; step();
    check("br_to5_pc", pc, 16'h0005);
    alu_result = 16'h0040; step(); BranchOut = 0;
    check("br_pc", pc, 16'h0040);
    check("br_ir_held", {12'h0, op}, 16'h0001);
    BranchOut = 1; alu_result = 16'h0005; step();
    IR_EN = 1; alu_result = 16'h0040; step();
    IR_EN = 0; BranchOut = 0;
    check("brfetch_inst_pc", inst_pc, 16'h0005);
    check("brfetch_pc", pc, 16'h0040);
    check("brfetch_op", {12'h0, op}, 16'h0002);

    // Load then store: store must not disturb MDR.
    use_mem = 0; forced_rdata = 16'hBEEF; IorD = 1; alu_result = 16'h0200; #1;
    check("ld_mem_addr", mem_addr, 16'h0200);
    step();
    check("ld_mdr", mdr, 16'hBEEF);
    MemWrite = 1; forced_rdata = 16'h1111; step();
    check("st_mdr_held", mdr, 16'hBEEF);
    check("st_pc_held", pc, 16'h0040);
    IorD = 0; MemWrite = 0; use_mem = 1;
    idle(1);

    // JAL-style fields from IR = 16'h4F80 fetched at 0x40.
    IR_EN = 1; step(); IR_EN = 0;
    check("jal_op", {12'h0, op}, 16'h0004);
    check("jal_imm12", imm12, 16'hFF80);
    check("jal_imm8", imm8, 16'hFF80);
    check("jal_rd", {12'h0, rd}, 16'h000F);
    check("jal_rs", {12'h0, rs}, 16'h0008);

    // PC wrap, then PCReset together with a fetch.
    BranchOut = 1; alu_result = 16'hFFFF; step(); BranchOut = 0;
    IR_EN = 1; step(); IR_EN = 0;
    check("wrap_pc", pc, 16'h0000);
    check("wrap_inst_pc", inst_pc, 16'hFFFF);
    check("wrap_op", {12'h0, op}, 16'h0003);
    PCReset = 1; IR_EN = 1; step(); PCReset = 0; IR_EN = 0;
    check("pcrst_pc", pc, 16'h0000);
    check("pcrst_op", {12'h0, op}, 16'h0000);
    check("pcrst_imm8", imm8, 16'h0023);
    check("pcrst_inst_pc", inst_pc, 16'h0000);
    idle(2);

    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-counter and instruction-register stage sitting directly upstream of `ControlUnit` in the multicycle RISCBlade core. It owns the PC, the instruction register (IR), the memory data register (MDR) and the instruction/data address mux, and it supplies the 4-bit `op` that `ControlUnit` decodes. It acts on `ControlUnit` strobes (`PCReset`, `IorD`, `IR_EN`, `BranchOut`, `MemWrite`), so that a fetch, PC update, branch redirect or data access happens exactly in the state that asserts it.

## Interface
Parameters:
- `WIDTH`, 16, instruction, data and address width; word-addressed memory.
- `RESET_VEC`, 16'h0000, PC value after `reset` or `PCReset`.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `PCReset`  in  1  from ControlUnit: reload PC with `RESET_VEC` (synchronous).
- `IR_EN`  in  1  from ControlUnit: capture `mem_rdata` into IR and advance PC.
- `IorD`  in  1  from ControlUnit: 0 = address memory with PC, 1 = with `alu_result`.
- `MemWrite`  in  1  from ControlUnit: current access is a store.
- `BranchOut`  in  1  from ControlUnit: load PC with `alu_result`.
- `alu_result`  in  WIDTH  data address or branch/jump target from the ALU.
- `mem_rdata`  in  WIDTH  combinational read data for `mem_addr`.
- `mem_addr`  out  WIDTH  memory address (combinational mux).
- `op`  out  4  IR[15:12], to ControlUnit.
- `rd`, `rs`  out  4 each  IR[11:8], IR[7:4].
- `imm8`  out  WIDTH  IR[7:0] sign-extended.
- `imm12`  out  WIDTH  IR[11:0] sign-extended (JAL offset).
- `pc`  out  WIDTH  current PC register.
- `inst_pc`  out  WIDTH  address the current IR was fetched from (link/branch base).
- `mdr`  out  WIDTH  registered load data.

## Operation
- `mem_addr = IorD ? alu_result : pc`; no register in the path.
- PC update priority per edge: `reset` > `PCReset` > `BranchOut` > `IR_EN` > hold.
  - `reset`/`PCReset`: PC <= `RESET_VEC`.
  - `BranchOut`: PC <= `alu_result`.
  - `IR_EN`: PC <= PC + 1, modulo 2^WIDTH (16'hFFFF wraps to 16'h0000, no flag).
- IR: on `IR_EN` (and not `reset`), IR <= `mem_rdata` and `inst_pc` <= PC (pre-increment). IR is otherwise held, including across `BranchOut` and `PCReset`.
- `IR_EN` together with `BranchOut`: IR still captures, `inst_pc` <= old PC, PC takes `alu_result` (branch wins over increment).
- `IR_EN` together with `PCReset`: IR captures, PC <= `RESET_VEC`.
- MDR: loads `mem_rdata` on any edge where `IorD=1` and `MemWrite=0`, otherwise holds. `IorD=1` with `MemWrite=1` leaves MDR unchanged.
- Decode fields (`op`, `rd`, `rs`, `imm8`, `imm12`) are combinational slices of IR and change only when IR changes.
- `IR_EN` with `IorD=1` is a ControlUnit protocol error. The block still obeys both rules: IR captures data-address read data.
- Reset values: PC = `RESET_VEC`, IR = 0 (so `op` = 4'b0000, all fields 0), `inst_pc` = 0, MDR = 0, `mem_addr` = `RESET_VEC` while `IorD=0`.
- Reset mid-instruction: everything returns to reset values on that edge. Operation resumes with a fetch from `RESET_VEC` at the first edge with `reset=0` and `IR_EN=1`.

## Timing
- Zero-latency combinational: `mem_addr`, decode fields from IR.
- One cycle: `op` reflects new IR in the cycle after the `IR_EN` edge. ControlUnit decode state samples `op` then.
- PC redirect: new PC visible the cycle after the `BranchOut` edge. The next fetch uses it.
- MDR is valid the cycle after the `IorD=1` read edge, which matches the ControlUnit writeback state.
- No handshake: memory is assumed single-cycle combinational read, and the block never stalls.

## Test plan
- Reset: `reset=1` for one edge with arbitrary prior state, then `reset=0` -> PC=16'h0000, IR=0, `op`=0000, MDR=0, `inst_pc`=0, `mem_addr`=0.
- Sequential fetch: memory[0..2] = 16'h0123, 16'h8456, 16'h1A7F. Pulse `IR_EN` every 4 cycles -> `op` = 0000, 1000, 0001 in turn; PC = 1, 2, 3; `inst_pc` = 0, 1, 2; `imm8` = 16'h007F after the third fetch.
- Branch: PC=5, `BranchOut=1`, `alu_result`=16'h0040 -> PC=16'h0040 next cycle. The same edge with `IR_EN=1` also -> IR captured, `inst_pc`=5, PC=16'h0040.
- Load/store: `IorD=1`, `alu_result`=16'h0200, `mem_rdata`=16'hBEEF, `MemWrite=0` -> `mem_addr`=16'h0200 combinationally, MDR=16'hBEEF next cycle. Repeat with `MemWrite=1`, `mem_rdata`=16'h1111 -> MDR remains 16'hBEEF.
- Wrap and PCReset: PC=16'hFFFF, `IR_EN` -> PC=16'h0000, `inst_pc`=16'hFFFF. Then `PCReset` with `IR_EN` -> PC=`RESET_VEC` and IR captured.
- JAL fields: IR loaded with 16'h4F80 -> `op`=0100, `imm12`=16'hFF80, `imm8`=16'hFF80, `rd`=4'hF.
